hilo_muldiv_unit: RTL and testbench

Multi-cycle signed multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the combinational ALU and is fed from the ID/EX register using the same 4-bit `alusignal` encoding. It replaces the ALU's combinational mult/div path with an iterative datapath and exposes a `busy` stall to the hazard unit. The HI and LO registers hold the results read by MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/div_restoring_step.sv | 25 ++
 rtl/hilo_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, FSM state type and default width for the HI/LO mul/div unit
//
// Purpose : constants shared between the ALU decoder and hilo_muldiv_unit.
// Contents: MULDIV_DATA_W (default operand width), OP_MUL / OP_DIV opcodes,
//           muldiv_state_t FSM state type.
package muldiv_pkg;

    localparam int MULDIV_DATA_W = 32;

    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational iteration of unsigned restoring division
//
// Purpose : trial-subtract the divisor from the shifted partial remainder.
// Ports   : partial  [DATA_W:0]   shifted remainder with next dividend bit in LSB
//           divisor  [DATA_W-1:0] divisor magnitude
//           next_rem [DATA_W-1:0] remainder after this iteration
//           q_bit                 quotient bit produced by this iteration
module div_restoring_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   partial,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              q_bit
);

    logic [DATA_W:0] diff;

    // partial < 2*divisor always holds, so DATA_W+1 bits cannot overflow and
    // the MSB of the difference is the borrow.
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[DATA_W];
    assign next_rem = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative signed multiply/divide unit with architectural HI/LO
//
// Purpose : multi-cycle MULT/DIV beside the EX-stage ALU; busy stalls ID/EX.
// Config  : define MULDIV_FAST_MUL_EN for a single-cycle multiply (IDLE -> FIX).
// Ports   : clk, rst (async active-high)
//           start, alusignal[3:0], a, b   op request, sampled at acceptance
//           abort                         flush, cancels in-flight op
//           hi_we, lo_we, wdata           MTHI/MTLO writes (IDLE only)
//           busy, done, div_by_zero       status
//           hi, lo                        architectural HI/LO registers
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MULDIV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        alusignal,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              abort,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = $clog2(DATA_W) + 1;

    muldiv_state_t       state;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opnd;     // multiplicand or divisor magnitude
    logic                op_div;
    logic                neg_q;    // sign of product or quotient
    logic                neg_r;    // sign of remainder (dividend sign)

    logic                is_mul, is_div, accept, b_zero;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W-1:0]   mul_addend;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   next_rem;
    logic                q_bit;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    assign is_mul = (alusignal == OP_MUL);
    assign is_div = (alusignal == OP_DIV);
    assign accept = (state == S_IDLE) && start && !abort && (is_mul || is_div);
    assign b_zero = (b == '0);

    // Negating the most-negative value yields itself, which read unsigned is its magnitude.
    assign mag_a = a[DATA_W-1] ? -a : a;
    assign mag_b = b[DATA_W-1] ? -b : b;

    assign mul_addend = acc[0] ? opnd : '0;
    assign mul_sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};

    div_restoring_step #(.DATA_W(DATA_W)) u_div_step (
        .partial  ({acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]}),
        .divisor  (opnd),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    always_comb begin
        prod   = neg_q ? -acc : acc;
        fix_hi = prod[2*DATA_W-1:DATA_W];
        fix_lo = prod[DATA_W-1:0];
        if (op_div) begin
            fix_lo = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            fix_hi = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        div_by_zero <= is_div && b_zero;
                        op_div      <= is_div;
                        neg_q       <= a[DATA_W-1] ^ b[DATA_W-1];
                        neg_r       <= a[DATA_W-1];
                        cnt         <= CW'(DATA_W);
                        if (is_div) begin
                            opnd <= mag_b;
                            if (b_zero) begin
                                // Zero accumulator and cleared signs make FIX write hi=lo=0.
                                acc   <= '0;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                state <= S_FIX;
                            end else begin
                                acc   <= {{DATA_W{1'b0}}, mag_a};
                                state <= S_RUN;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc   <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
                            state <= S_FIX;
`else
                            opnd  <= mag_a;
                            acc   <= {{DATA_W{1'b0}}, mag_b};
                            state <= S_RUN;
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= op_div ? {next_rem, acc[DATA_W-2:0], q_bit}
                                      : {mul_sum, acc[DATA_W-1:1]};
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!abort) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard testbench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    alusignal = 4'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          abort = 1'b0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    hilo_muldiv_unit #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alusignal   (alusignal),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic; SV '/' truncates toward zero and
    // '%' takes the dividend's sign, matching the MIPS HI/LO rules.
    function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t   r;
        longint sa, sbv, p, q, m;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        r.d = 1'b0;
        if (op == OP_MUL) begin
            p   = sa * sbv;
            r.h = p[63:32];
            r.l = p[31:0];
        end else if (sbv == 0) begin
            r.h = '0;
            r.l = '0;
            r.d = 1'b1;
        end else begin
            q   = sa / sbv;
            m   = sa % sbv;
            r.h = m[31:0];
            r.l = q[31:0];
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] bv);
        if (op == OP_DIV && bv == '0) return 1;
        if (op == OP_MUL && FAST) return 1;
        return W + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                if (hi !== mon_e.h || lo !== mon_e.l || div_by_zero !== mon_e.d) begin
                    errors++;
                    $display("FAIL result hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                             hi, lo, div_by_zero, mon_e.h, mon_e.l, mon_e.d);
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        int   lat;
        bit   busy_ok;
        e = ref_op(op, av, bv);
        sb.push_back(e);
        alusignal = op;
        a         = av;
        b         = bv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("dbz_at_accept", div_by_zero, e.d);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_latency(op, bv));
        check("busy_held", busy_ok, 1);
        check("idle_after_done", busy, 0);
    endtask

    task automatic start_only(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        alusignal = op;
        a         = av;
        b         = bv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic write_hilo(input bit to_hi, input logic [31:0] d);
        wdata = d;
        hi_we = to_hi;
        lo_we = !to_hi;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    logic [31:0] hi_prev;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);

        run_op(OP_MUL, 32'd7, -32'sd3);
        check("mul7x-3_hi", hi, 32'hFFFF_FFFF);
        check("mul7x-3_lo", lo, 32'hFFFF_FFEB);
        run_op(OP_DIV, -32'sd7, 32'd2);
        check("div-7/2_lo", lo, 32'hFFFF_FFFD);
        check("div-7/2_hi", hi, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0);
        run_op(OP_DIV, 32'd5, 32'd0);
        check("dbz_set", div_by_zero, 1);
        run_op(OP_MUL, 32'd3, 32'd4);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        check("mul_2_32_hi", hi, 32'd1);
        check("mul_2_32_lo", lo, 32'd0);

        // Non-mul/div opcode and start-with-abort in IDLE are both dropped.
        alusignal = 4'b0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        check("nonop_ignored", busy, 0);
        alusignal = OP_MUL;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_dropped", busy, 0);

        // Abort mid-op leaves HI/LO untouched and never pulses done.
        write_hilo(1'b1, 32'h11);
        check("mthi_11", hi, 32'h11);
        write_hilo(1'b0, 32'h22);
        check("mtlo_22", lo, 32'h22);
        start_only(FAST ? OP_DIV : OP_MUL, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_hi", hi, 32'h11);
        check("abort_lo", lo, 32'h22);

        // Asynchronous reset mid-op clears HI/LO before the next edge.
        start_only(OP_MUL, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        check("rst_mid_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // MTHI and a second start while busy are both ignored.
        write_hilo(1'b1, 32'h5A);
        hi_prev = hi;
        fork
            run_op(OP_DIV, 32'd100, 32'd7);
            begin
                repeat (3) @(posedge clk);
                #2;
                hi_we = 1'b1;
                wdata = 32'hAB;
                @(posedge clk);
                #2;
                hi_we = 1'b0;
                check("mthi_busy_ignored", hi, hi_prev);
                repeat (2) @(posedge clk);
                #2;
                start     = 1'b1;
                alusignal = OP_DIV;
                a         = 32'd9;
                b         = 32'd0;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
        join
        write_hilo(1'b1, 32'hAB);
        check("mthi_idle", hi, 32'hAB);

        // Randomized back-to-back ops; each start lands in the done cycle of the previous op.
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 9);
                default: ;
            endcase
            run_op(rop, ra, rb);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
